// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    // Default fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h6000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force an address onto a 4-byte instruction boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear. Any depth >= 1 is supported; pointers wrap
// explicitly so the same block also serves as the small PC tag queue.
// Storage is not reset; only pointers and count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Qualify requests: never pop empty, push into a full FIFO only alongside a pop.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data storage write port; a cleared cycle writes nothing.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: keeps up to MAX_INFLIGHT reads outstanding to
// an in-order instruction memory, buffers returned (pc, inst) pairs, and
// discards responses that belong to requests made before a redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH  = 8,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [31:0]                      flush_pc,
    output logic [31:0]                      imem_addr,
    output logic [3:0]                       imem_rmask,
    input  logic                             imem_resp,
    input  logic [31:0]                      imem_rdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_inst,
    output logic [31:0]                      out_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    logic [31:0]      fetch_pc;
    logic [INF_W-1:0] inflight;
    logic [INF_W-1:0] drop_cnt;
    logic [OCC_W-1:0] count;
    logic [INF_W-1:0] tag_count;
    logic [31:0]      tag_pc;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic [OCC_W:0]   credit_used;
    logic             issue;
    logic             resp_seen;
    logic             resp_keep;
    logic             tag_pop;
    logic             pop;

    // Issue and response qualification. Credits count every outstanding read,
    // stale ones included, so a kept response always finds a free slot.
    always_comb begin
        credit_used     = {1'b0, count} + (OCC_W + 1)'(inflight);
        issue           = !rst && !flush
                          && (inflight < INF_W'(MAX_INFLIGHT))
                          && (credit_used < (OCC_W + 1)'(QUEUE_DEPTH));
        resp_seen       = imem_resp && (inflight != '0);
        tag_pop         = resp_seen && (drop_cnt == '0);
        resp_keep       = tag_pop && !flush && (tag_count != '0);
        pop             = out_valid && out_ready && !flush;
        push_entry.pc   = tag_pc;
        push_entry.inst = imem_rdata;
    end

    // Fetch address: reset vector, redirect target, or sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (flush) begin
            fetch_pc <= align_word(flush_pc);
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Outstanding-read counter; tracks real memory traffic across redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, resp_seen})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Stale-response counter. On a redirect every read still outstanding after
    // this cycle is stale, which also covers back-to-back redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= inflight - INF_W'(resp_seen);
        end else if (resp_seen && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // PC of every live request, consumed in order by its response.
    fetch_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .T     (logic [31:0])
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (tag_pop),
        .head      (tag_pc),
        .count     (tag_count)
    );

    // Decoded-side buffer of returned instructions.
    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_addr  = fetch_pc;
    assign imem_rmask = issue ? 4'hF : 4'h0;
    assign out_valid  = (count != '0);
    assign out_inst   = out_valid ? head.inst : 32'h0;
    assign out_pc     = out_valid ? head.pc : 32'h0;
    assign occupancy  = count;

endmodule
